// File: rtl/life_cmd_sched_if.sv
// life_cmd_sched_if
//   Host-side request/response bundle for life_cmd_sched.
//   master : host control logic (drives requests, receives responses)
//   slave  : the scheduler (accepts requests, returns responses)
//   Signals:
//     host_valid  request valid
//     host_ready  scheduler accepts the request this cycle
//     host_we     1 = write, 0 = read
//     host_x/y    cell address
//     host_wdata  write data
//     rsp_valid   one-cycle pulse: read data valid or write acknowledged
//     rsp_rdata   read data, held until the next read response
interface life_cmd_sched_if #(
  parameter int N_PX_BITS     = 4,
  parameter int N_PY_BITS     = 4,
  parameter int PE_STATE_BITS = 1
);
  logic                     host_valid;
  logic                     host_ready;
  logic                     host_we;
  logic [N_PX_BITS-1:0]     host_x;
  logic [N_PY_BITS-1:0]     host_y;
  logic [PE_STATE_BITS-1:0] host_wdata;
  logic                     rsp_valid;
  logic [PE_STATE_BITS-1:0] rsp_rdata;

  modport master (
    output host_valid, host_we, host_x, host_y, host_wdata,
    input  host_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  host_valid, host_we, host_x, host_y, host_wdata,
    output host_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/life_cmd_sched.sv
// life_cmd_sched
//   Shares the pe_array command/address port between host cell read/write
//   requests and generation-step requests (Timer trigger while free-running,
//   or a single-step pulse). Runs each command to completion, times out
//   writes that never get pe_written, and returns read data. All outputs
//   are registered.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     trigger, run      Timer tick; trigger requests a step only when run=1
//     step_req          single-step request, honoured regardless of run
//     host              life_cmd_sched_if.slave (request + response)
//     err_timeout       sticky write-ack timeout, cleared only by rst
//     busy              a command is in progress
//     pe_cmd            opcode to pe_array
//     pe_adr_x/y        cell address to pe_array
//     pe_state_o        write data to pe_array
//     pe_state_i        read data from pe_array
//     pe_written        write-complete from pe_array
//
//   Optional build macro LIFE_SCHED_GEN_CNT_EN adds:
//     gen_count [15:0]  completed steps, wrapping
//     step_drop [7:0]   step requests merged into an already pending one,
//                       saturating
module life_cmd_sched #(
  parameter int N_PX_BITS     = 4,
  parameter int N_PY_BITS     = 4,
  parameter int PE_STATE_BITS = 1,
  parameter int PE_CMD_BITS   = 2,
  parameter int STEP_CYCLES   = 2,
  parameter int RD_LAT        = 1,
  parameter int WR_TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic                     run,
  input  logic                     step_req,
  life_cmd_sched_if.slave          host,
  output logic                     err_timeout,
  output logic                     busy,
  output logic [PE_CMD_BITS-1:0]   pe_cmd,
  output logic [N_PX_BITS-1:0]     pe_adr_x,
  output logic [N_PY_BITS-1:0]     pe_adr_y,
  output logic [PE_STATE_BITS-1:0] pe_state_o,
  input  logic [PE_STATE_BITS-1:0] pe_state_i,
  input  logic                     pe_written
`ifdef LIFE_SCHED_GEN_CNT_EN
  ,
  output logic [15:0]              gen_count,
  output logic [7:0]               step_drop
`endif
);

  localparam logic [PE_CMD_BITS-1:0] CMD_NOP   = PE_CMD_BITS'(2'd0);
  localparam logic [PE_CMD_BITS-1:0] CMD_STEP  = PE_CMD_BITS'(2'd1);
  localparam logic [PE_CMD_BITS-1:0] CMD_WRITE = PE_CMD_BITS'(2'd2);
  localparam logic [PE_CMD_BITS-1:0] CMD_READ  = PE_CMD_BITS'(2'd3);

  // Counter values on the final cycle of each state.
  localparam logic [7:0] WR_LAST   = 8'(WR_TIMEOUT - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  state_t                   state_r, state_s;
  logic [7:0]               cnt_r, cnt_s;
  logic                     step_pend_r, step_pend_s;
  logic                     last_host_r, last_host_s;  // 1 = last grant went to the host
  logic                     step_set_s;
  logic                     grant_host_s, grant_step_s;
  logic                     wr_ack_s, wr_to_s, rd_done_s;
  logic                     host_ready_r, host_ready_s;
  logic                     rsp_valid_r, rsp_valid_s;
  logic                     busy_s;
  logic [PE_CMD_BITS-1:0]   pe_cmd_s;
  logic [PE_STATE_BITS-1:0] rsp_rdata_r;

  assign host.host_ready = host_ready_r;
  assign host.rsp_valid  = rsp_valid_r;
  assign host.rsp_rdata  = rsp_rdata_r;

  // State register plus arbitration bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      step_pend_r <= 1'b0;
      last_host_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      step_pend_r <= step_pend_s;
      last_host_r <= last_host_s;
    end
  end

  // Next-state logic: arbitration in IDLE, command sequencing elsewhere.
  always_comb begin
    state_s      = state_r;
    grant_host_s = 1'b0;
    grant_step_s = 1'b0;
    wr_ack_s     = 1'b0;
    wr_to_s      = 1'b0;
    rd_done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // host_ready already encodes the round-robin decision, so a valid
        // host request seen with ready high always wins over the step.
        if (host.host_valid && host_ready_r) begin
          grant_host_s = 1'b1;
          state_s      = host.host_we ? ST_WR : ST_RD;
        end else if (step_pend_r) begin
          grant_step_s = 1'b1;
          state_s      = ST_STEP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if (pe_written) begin
          wr_ack_s = 1'b1;
          state_s  = ST_IDLE;
        end else if (cnt_r == WR_LAST) begin
          wr_to_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_RD: begin
        if (cnt_r == RD_LAST) begin
          rd_done_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_STEP: begin
        if (cnt_r == STEP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STEP;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // Cycle counter runs only while staying inside a command.
    if ((state_r != ST_IDLE) && (state_s != ST_IDLE)) begin
      cnt_s = cnt_r + 8'd1;
    end else begin
      cnt_s = 8'd0;
    end

    // A new request in the grant cycle re-arms the pending flag.
    step_set_s  = (trigger & run) | step_req;
    step_pend_s = step_set_s | (step_pend_r & ~grant_step_s);

    if (grant_host_s) begin
      last_host_s = 1'b1;
    end else if (grant_step_s) begin
      last_host_s = 1'b0;
    end else begin
      last_host_s = last_host_r;
    end
  end

  // Output decode for the coming cycle, registered below.
  always_comb begin
    case (state_s)
      ST_WR:   pe_cmd_s = CMD_WRITE;
      ST_RD:   pe_cmd_s = CMD_READ;
      ST_STEP: pe_cmd_s = CMD_STEP;
      default: pe_cmd_s = CMD_NOP;
    endcase
    busy_s      = (state_s != ST_IDLE);
    rsp_valid_s = wr_ack_s | wr_to_s | rd_done_s;
    // Host is offered the port unless a pending step is owed its turn.
    host_ready_s = (state_s == ST_IDLE) && !(step_pend_s && last_host_s);
  end

  // Registered outputs and captured host address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_cmd       <= CMD_NOP;
      busy         <= 1'b0;
      host_ready_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= '0;
      err_timeout  <= 1'b0;
      pe_adr_x     <= '0;
      pe_adr_y     <= '0;
      pe_state_o   <= '0;
    end else begin
      pe_cmd       <= pe_cmd_s;
      busy         <= busy_s;
      host_ready_r <= host_ready_s;
      rsp_valid_r  <= rsp_valid_s;
      if (rd_done_s) begin
        rsp_rdata_r <= pe_state_i;
      end
      if (wr_to_s) begin
        err_timeout <= 1'b1;
      end
      if (grant_host_s) begin
        pe_adr_x   <= host.host_x;
        pe_adr_y   <= host.host_y;
        pe_state_o <= host.host_wdata;
      end
    end
  end

`ifdef LIFE_SCHED_GEN_CNT_EN
  // Generation counter and merged-request counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_count <= 16'd0;
      step_drop <= 8'd0;
    end else begin
      if ((state_r == ST_STEP) && (state_s == ST_IDLE)) begin
        gen_count <= gen_count + 16'd1;
      end
      if (step_set_s && step_pend_r && !grant_step_s && (step_drop != 8'hFF)) begin
        step_drop <= step_drop + 8'd1;
      end
    end
  end
`endif

endmodule
